systolic_ctrl: RTL and testbench

- Sequencer for an N x N output-stationary array of MAC processing elements. Each PE registers its row and column operands eastward and southward and accumulates row*col into a local result.
- The block reads operand vectors from the A buffer (one column of A per address) and the B buffer (one row of B per address), both with 1-cycle read latency. It applies per-lane diagonal skew, drives the west-edge row feeds and north-edge column feeds, and clears the array before a job.
- It flags results valid once the last MAC has landed.
- It sits between the operand buffers and the PE array, under a start/done handshake from the system controller.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_ctrl_if.sv | 38 +++
 rtl/systolic_ctrl_skew_line.sv | 32 +++
 rtl/systolic_ctrl.sv | 128 ++++++++++++
 tb/tb_systolic_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Default geometry lives here so the interface, controller and bench agree on it.
package systolic_pkg;

    localparam int SYS_N    = 5;
    localparam int SYS_BW   = 8;
    localparam int FEED_LEN = 3 * SYS_N - 1;
    localparam int CNT_W    = $clog2(3 * SYS_N);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        DONE
    } state_t;

    function automatic logic [SYS_BW-1:0] lane(input logic [SYS_N*SYS_BW-1:0] vec, input int i);
        return vec[i*SYS_BW +: SYS_BW];
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Start/done handshake, operand-buffer read ports and array edge feeds.
// master = system controller plus buffers; slave = the sequencer.
interface systolic_ctrl_if
    import systolic_pkg::*;
#(
    parameter int BW = SYS_BW,
    parameter int N  = SYS_N
);
    localparam int AW = $clog2(N);

    logic          start;
    logic          acc;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          a_rd_en;
    logic [AW-1:0] a_rd_addr;
    logic [N*BW-1:0] a_rd_data;
    logic          b_rd_en;
    logic [AW-1:0] b_rd_addr;
    logic [N*BW-1:0] b_rd_data;
    logic [N*BW-1:0] row_feed;
    logic [N*BW-1:0] col_feed;
    logic          pe_rst_n;

    modport master (
        output start, acc, a_rd_data, b_rd_data,
        input  busy, done, res_valid, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  row_feed, col_feed, pe_rst_n
    );

    modport slave (
        input  start, acc, a_rd_data, b_rd_data,
        output busy, done, res_valid, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output row_feed, col_feed, pe_rst_n
    );

endinterface

// File: rtl/systolic_ctrl_skew_line.sv
// DEPTH-stage register delay line with synchronous clear; DEPTH=0 is a wire.
// Latency DEPTH cycles, no backpressure.
module skew_line #(
    parameter int BW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [BW-1:0] din,
    output logic [BW-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = clk ^ clr;
        assign dout        = din;
    end else begin : g_shift
        logic [BW-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (clr) begin
                for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            end else begin
                stage[0] <= din;
                for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary MAC array: clear, read, skew and feed operands.
// Job = 1 clear cycle (unless acc) + 3N-1 feed cycles + 1 done cycle; start is ignored while busy.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int BW = SYS_BW,
    parameter int N  = SYS_N
) (
    input  logic           clk,
    input  logic           rst,
    systolic_ctrl_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int TW = $clog2(3 * N);
    localparam logic [TW-1:0] T_LAST    = TW'(3 * N - 2);
    localparam logic [TW-1:0] T_RD_LAST = TW'(N - 1);

    state_t          state;
    logic [TW-1:0]   t;
    logic            busy_q;
    logic            done_q;
    logic            res_valid_q;
    logic            rd_en_q;
    logic [AW-1:0]   rd_addr_q;
    logic            pe_rst_n_q;
    logic            rd_vld;
    logic [N*BW-1:0] a_qual;
    logic [N*BW-1:0] b_qual;
    logic [N*BW-1:0] row_w;
    logic [N*BW-1:0] col_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            t           <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pe_rst_n_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            pe_rst_n_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        t           <= '0;
                        // acc decides the path here, so later toggles cannot matter
                        if (bus.acc) begin
                            state     <= FEED;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                        end else begin
                            state      <= CLEAR;
                            pe_rst_n_q <= 1'b0;
                        end
                    end
                end
                CLEAR: begin
                    state     <= FEED;
                    t         <= '0;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                end
                FEED: begin
                    if (t == T_LAST) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        res_valid_q <= 1'b1;
                    end else begin
                        t <= t + 1'b1;
                        if (t < T_RD_LAST) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= AW'(t + 1'b1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Buffer data is only trusted the cycle after a read; otherwise zeros enter the skew.
    always_ff @(posedge clk) begin
        if (rst) rd_vld <= 1'b0;
        else     rd_vld <= rd_en_q;
    end

    assign a_qual = rd_vld ? bus.a_rd_data : '0;
    assign b_qual = rd_vld ? bus.b_rd_data : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.BW(BW), .DEPTH(i)) u_row_skew (
            .clk  (clk),
            .clr  (rst),
            .din  (a_qual[i*BW +: BW]),
            .dout (row_w[i*BW +: BW])
        );
        skew_line #(.BW(BW), .DEPTH(i)) u_col_skew (
            .clk  (clk),
            .clr  (rst),
            .din  (b_qual[i*BW +: BW]),
            .dout (col_w[i*BW +: BW])
        );
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.a_rd_en   = rd_en_q;
    assign bus.b_rd_en   = rd_en_q;
    assign bus.a_rd_addr = rd_addr_q;
    assign bus.b_rd_addr = rd_addr_q;
    assign bus.pe_rst_n  = pe_rst_n_q;
    assign bus.row_feed  = row_w;
    assign bus.col_feed  = col_w;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed + randomized bench: buffer model, behavioural PE array and matrix-product reference.
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int N  = SYS_N;
    localparam int BW = SYS_BW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.BW(BW), .N(N)) bus ();
    systolic_ctrl #(.BW(BW), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    int A [N][N];
    int B [N][N];
    int ref_c [N][N];
    int pe [N][N];
    int rh [N][N];
    int ch [N][N];

    // Operand buffers: one-cycle read latency, 0xFF junk when not read.
    always @(posedge clk) begin
        logic [N*BW-1:0] av;
        logic [N*BW-1:0] bv;
        for (int i = 0; i < N; i++) begin
            av[i*BW +: BW] = bus.a_rd_en ? BW'(A[i][bus.a_rd_addr]) : '1;
            bv[i*BW +: BW] = bus.b_rd_en ? BW'(B[bus.b_rd_addr][i]) : '1;
        end
        bus.a_rd_data <= av;
        bus.b_rd_data <= bv;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, and update the PE array model.
    task automatic step();
        @(posedge clk);
        #1;
        for (int d = N - 1; d > 0; d--) begin
            for (int i = 0; i < N; i++) begin
                rh[d][i] = rh[d-1][i];
                ch[d][i] = ch[d-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            rh[0][i] = int'(lane(bus.row_feed, i));
            ch[0][i] = int'(lane(bus.col_feed, i));
        end
        if (bus.pe_rst_n !== 1'b1) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe[i][j] = 0;
                    rh[i][j] = 0;
                    ch[i][j] = 0;
                end
        end else begin
            // PE(i,j) sees row lane i delayed by j and column lane j delayed by i
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    pe[i][j] += rh[j][i] * ch[i][j];
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                case (mode)
                    0:       begin A[i][j] = (i == j) ? 1 : 0; B[i][j] = (i == j) ? 1 : 0; end
                    1:       begin A[i][j] = 2; B[i][j] = 2; end
                    default: begin A[i][j] = int'($urandom_range(0, 255)); B[i][j] = int'($urandom_range(0, 255)); end
                endcase
            end
    endtask

    task automatic run_job(input bit a, input bit hold);
        int fs;
        int dn;
        int t;
        bit in_feed;
        int er;
        int ec;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int e;
                e = a ? ref_c[i][j] : 0;
                for (int k = 0; k < N; k++) e += A[i][k] * B[k][j];
                ref_c[i][j] = e;
            end
        fs = a ? 1 : 2;
        dn = fs + 3 * N - 1;
        bus.start = 1'b1;
        bus.acc   = a;
        for (int c = 1; c <= dn + 1; c++) begin
            step();
            if (c == 1) begin
                bus.acc = ~a;
                if (!hold) bus.start = 1'b0;
            end
            if (c == dn + 1) bus.start = 1'b0;
            t       = c - fs;
            in_feed = (c >= fs) && (c < dn);
            check($sformatf("busy c%0d", c), bus.busy, (c < dn));
            check($sformatf("done c%0d", c), bus.done, (c == dn));
            check($sformatf("res_valid c%0d", c), bus.res_valid, (c >= dn));
            check($sformatf("pe_rst_n c%0d", c), bus.pe_rst_n, !(a == 0 && c == 1));
            check($sformatf("a_rd_en c%0d", c), bus.a_rd_en, in_feed && t < N);
            check($sformatf("b_rd_en c%0d", c), bus.b_rd_en, in_feed && t < N);
            if (in_feed && t < N) begin
                check($sformatf("a_rd_addr c%0d", c), bus.a_rd_addr, t);
                check($sformatf("b_rd_addr c%0d", c), bus.b_rd_addr, t);
            end
            for (int i = 0; i < N; i++) begin
                er = 0;
                ec = 0;
                if (in_feed && t >= 1 + i && t <= N + i) begin
                    er = A[i][t-1-i];
                    ec = B[t-1-i][i];
                end
                check($sformatf("row_feed[%0d] c%0d", i, c), lane(bus.row_feed, i), er);
                check($sformatf("col_feed[%0d] c%0d", i, c), lane(bus.col_feed, i), ec);
            end
        end
        step();
        check("idle_after_job busy", bus.busy, 0);
        check("idle_after_job res_valid", bus.res_valid, 1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("C[%0d][%0d]", i, j), pe[i][j], ref_c[i][j]);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.acc   = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ref_c[i][j] = 0; pe[i][j] = 0; rh[i][j] = 0; ch[i][j] = 0;
            end
        fill(0);
        for (int k = 0; k < 3; k++) step();
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst res_valid", bus.res_valid, 0);
        check("rst a_rd_en", bus.a_rd_en, 0);
        check("rst b_rd_en", bus.b_rd_en, 0);
        check("rst a_rd_addr", bus.a_rd_addr, 0);
        check("rst b_rd_addr", bus.b_rd_addr, 0);
        check("rst row_feed", bus.row_feed, 0);
        check("rst col_feed", bus.col_feed, 0);
        check("rst pe_rst_n", bus.pe_rst_n, 0);
        rst = 1'b0;
        step();
        check("rst release pe_rst_n", bus.pe_rst_n, 1);
        check("rst release busy", bus.busy, 0);

        fill(0);
        run_job(1'b0, 1'b0);
        fill(1);
        run_job(1'b0, 1'b0);
        run_job(1'b1, 1'b0);
        fill(2);
        run_job(1'b0, 1'b1);
        fill(2);
        run_job(1'b1, 1'b0);

        // Reset in the middle of FEED (t=6)
        fill(2);
        bus.start = 1'b1;
        bus.acc   = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
        end
        rst = 1'b1;
        step();
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        check("midrst res_valid", bus.res_valid, 0);
        check("midrst a_rd_en", bus.a_rd_en, 0);
        check("midrst row_feed", bus.row_feed, 0);
        check("midrst col_feed", bus.col_feed, 0);
        check("midrst pe_rst_n", bus.pe_rst_n, 0);
        rst = 1'b0;
        step();
        check("midrst release pe_rst_n", bus.pe_rst_n, 1);
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("midrst quiet done c%0d", c), bus.done, 0);
            check($sformatf("midrst quiet busy c%0d", c), bus.busy, 0);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) ref_c[i][j] = 0;

        fill(2);
        run_job(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
